// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: lsu_op field layout, size/kind codes,
// FSM state encoding and small decode helpers.
package lsu_pkg;

    localparam int OP_SZ_LSB   = 0;
    localparam int OP_UNS_BIT  = 2;
    localparam int OP_KIND_LSB = 3;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] K_PASS  = 2'b00;
    localparam logic [1:0] K_LOAD  = 2'b01;
    localparam logic [1:0] K_STORE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // The reserved encodings fold onto word size and pass-through kind.
    function automatic logic [1:0] op_size(input logic [1:0] sz);
        return (sz == 2'b11) ? SZ_W : sz;
    endfunction

    function automatic logic [1:0] op_kind(input logic [1:0] k);
        return (k == K_LOAD || k == K_STORE) ? k : K_PASS;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        return ((sz == SZ_H) && lo[0]) || ((sz == SZ_W) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic for the LSU: store mask/data replication and load extract/extend.
// Misaligned offsets are pulled down to the natural boundary of the access size.
module lsu_lane
    import lsu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    addr_lo,
    input  logic [1:0]    size,
    input  logic          uns,
    input  logic [DW-1:0] store_data,
    input  logic [DW-1:0] rdata,
    output logic [3:0]    wmask,
    output logic [DW-1:0] wdata,
    output logic [DW-1:0] ldata
);

    logic [1:0]    off;
    logic [DW-1:0] r;

    always_comb begin
        off   = addr_lo;
        wmask = 4'b1111;
        wdata = store_data;
        if (is_misaligned(size, addr_lo)) begin
            off = (size == SZ_H) ? {addr_lo[1], 1'b0} : 2'b00;
        end
        r     = rdata >> {off, 3'b000};
        ldata = r;
        case (size)
            SZ_B: begin
                wmask = 4'b0001 << off;
                wdata = {4{store_data[7:0]}};
                ldata = uns ? {{(DW-8){1'b0}}, r[7:0]} : {{(DW-8){r[7]}}, r[7:0]};
            end
            SZ_H: begin
                wmask = 4'b0011 << off;
                wdata = {2{store_data[15:0]}};
                ldata = uns ? {{(DW-16){1'b0}}, r[15:0]} : {{(DW-16){r[15]}}, r[15:0]};
            end
            default: begin
                wmask = 4'b1111;
                wdata = store_data;
                ldata = r;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store stage: one outstanding word-aligned memory request, one writeback beat per op.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of forcing them aligned.
module lsu
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] exu_data,
    input  logic [DW-1:0] store_data,
    input  logic [4:0]    lsu_op,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_req_wen,
    output logic [AW-1:0] mem_req_addr,
    output logic [DW-1:0] mem_req_wdata,
    output logic [3:0]    mem_req_wmask,
    input  logic          mem_resp_valid,
    input  logic [DW-1:0] mem_resp_rdata,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [DW-1:0] wb_data,
    output logic          wb_fault
);

    state_t        state_q, state_d;
    logic [1:0]    lo_q, lo_d;
    logic [4:0]    op_q, op_d;
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic [DW-1:0] req_wdata_q, req_wdata_d;
    logic [3:0]    req_wmask_q, req_wmask_d;
    logic          req_wen_q, req_wen_d;
    logic [DW-1:0] wb_data_q, wb_data_d;

    logic          in_sel;
    logic [1:0]    lane_lo;
    logic [4:0]    lane_op;
    logic [3:0]    lane_wmask;
    logic [DW-1:0] lane_wdata;
    logic [DW-1:0] lane_ldata;
    logic [1:0]    kind_in;
    logic [1:0]    kind_q;

    // In IDLE the lane decodes the incoming op to build the request; afterwards the latched op.
    assign in_sel  = (state_q == S_IDLE);
    assign lane_lo = in_sel ? exu_data[1:0] : lo_q;
    assign lane_op = in_sel ? lsu_op : op_q;
    assign kind_in = op_kind(lsu_op[OP_KIND_LSB +: 2]);
    assign kind_q  = op_kind(op_q[OP_KIND_LSB +: 2]);

    lsu_lane #(.DW(DW)) u_lane (
        .addr_lo    (lane_lo),
        .size       (op_size(lane_op[OP_SZ_LSB +: 2])),
        .uns        (lane_op[OP_UNS_BIT]),
        .store_data (store_data),
        .rdata      (mem_resp_rdata),
        .wmask      (lane_wmask),
        .wdata      (lane_wdata),
        .ldata      (lane_ldata)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic wb_fault_q, wb_fault_d;
    logic misal_in;
    assign misal_in = is_misaligned(op_size(lsu_op[OP_SZ_LSB +: 2]), exu_data[1:0]);
    assign wb_fault = wb_fault_q;
`else
    assign wb_fault = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        op_d        = op_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wmask_d = req_wmask_q;
        req_wen_d   = req_wen_q;
        wb_data_d   = wb_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
        wb_fault_d  = wb_fault_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    lo_d        = exu_data[1:0];
                    op_d        = lsu_op;
                    req_addr_d  = {exu_data[AW-1:2], 2'b00};
                    req_wdata_d = lane_wdata;
                    req_wmask_d = (kind_in == K_STORE) ? lane_wmask : 4'b0000;
                    req_wen_d   = (kind_in == K_STORE);
`ifdef LSU_MISALIGN_TRAP_EN
                    wb_fault_d  = misal_in && (kind_in != K_PASS);
`endif
                    if (kind_in == K_PASS) begin
                        wb_data_d = exu_data;
                        state_d   = S_DONE;
                    end
`ifdef LSU_MISALIGN_TRAP_EN
                    else if (misal_in) begin
                        wb_data_d = exu_data;
                        state_d   = S_DONE;
                    end
`endif
                    else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    wb_data_d = (kind_q == K_LOAD) ? lane_ldata : '0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lo_q        <= '0;
            op_q        <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wmask_q <= '0;
            req_wen_q   <= 1'b0;
            wb_data_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            wb_fault_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            op_q        <= op_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wmask_q <= req_wmask_d;
            req_wen_q   <= req_wen_d;
            wb_data_q   <= wb_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
            wb_fault_q  <= wb_fault_d;
`endif
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign mem_req_valid = (state_q == S_REQ);
    assign wb_valid      = (state_q == S_DONE);
    assign mem_req_wen   = req_wen_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wmask = req_wmask_q;
    assign wb_data       = wb_data_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: pass-through, loads, stores, backpressure, misalign and mid-op reset.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] exu_data;
    logic [31:0] store_data;
    logic [4:0]  lsu_op;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic        wb_fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .exu_data       (exu_data),
        .store_data     (store_data),
        .lsu_op         (lsu_op),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_wen    (mem_req_wen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_data        (wb_data),
        .wb_fault       (wb_fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        in_valid       = 1'b0;
        exu_data       = '0;
        store_data     = '0;
        lsu_op         = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        wb_ready       = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("rst_in_ready", in_ready, 1);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_fault", wb_fault, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        chk("rst_req_wmask", mem_req_wmask, 0);
        chk("rst_req_wdata", mem_req_wdata, 0);
        chk("rst_req_wen", mem_req_wen, 0);

        // pass-through
        in_valid = 1'b1; lsu_op = 5'b00000; exu_data = 32'h0000_1234; wb_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("pass_wb_valid", wb_valid, 1);
        chk("pass_wb_data", wb_data, 32'h0000_1234);
        chk("pass_no_req", mem_req_valid, 0);
        chk("pass_in_ready", in_ready, 0);
        step();
        chk("pass_wb_drop", wb_valid, 0);
        chk("pass_back_idle", in_ready, 1);

        // signed byte load
        in_valid = 1'b1; lsu_op = 5'b01000; exu_data = 32'h8000_0003; mem_req_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lbs_req_valid", mem_req_valid, 1);
        chk("lbs_req_addr", mem_req_addr, 32'h8000_0000);
        chk("lbs_req_wmask", mem_req_wmask, 4'b0000);
        chk("lbs_req_wen", mem_req_wen, 0);
        step();
        chk("lbs_req_drop", mem_req_valid, 0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h80FF_FF7F;
        step();
        mem_resp_valid = 1'b0;
        chk("lbs_wb_valid", wb_valid, 1);
        chk("lbs_wb_data", wb_data, 32'hFFFF_FF80);
        step();
        chk("lbs_idle", in_ready, 1);

        // unsigned byte load
        in_valid = 1'b1; lsu_op = 5'b01100; exu_data = 32'h8000_0003;
        step();
        in_valid = 1'b0;
        step();
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h80FF_FF7F;
        step();
        mem_resp_valid = 1'b0;
        chk("lbu_wb_data", wb_data, 32'h0000_0080);
        step();

        // half store
        in_valid = 1'b1; lsu_op = 5'b10001; exu_data = 32'h8000_0002; store_data = 32'hDEAD_BEEF;
        step();
        in_valid = 1'b0;
        chk("sh_req_valid", mem_req_valid, 1);
        chk("sh_req_wen", mem_req_wen, 1);
        chk("sh_req_addr", mem_req_addr, 32'h8000_0000);
        chk("sh_req_wmask", mem_req_wmask, 4'b1100);
        chk("sh_req_wdata", mem_req_wdata, 32'hBEEF_BEEF);
        step();
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1111_1111;
        step();
        mem_resp_valid = 1'b0;
        chk("sh_wb_valid", wb_valid, 1);
        chk("sh_wb_data", wb_data, 32'h0000_0000);
        step();

        // backpressure on request and writeback; extra in_valid must be ignored
        in_valid = 1'b1; lsu_op = 5'b01010; exu_data = 32'h8000_0010; mem_req_ready = 1'b0;
        step();
        exu_data = 32'hFFFF_FFF0; store_data = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            chk("bp_req_valid", mem_req_valid, 1);
            chk("bp_req_addr", mem_req_addr, 32'h8000_0010);
            chk("bp_req_wmask", mem_req_wmask, 4'b0000);
            chk("bp_in_ready", in_ready, 0);
            step();
        end
        mem_req_ready = 1'b1;
        chk("bp_req_hold", mem_req_valid, 1);
        step();
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_5678; wb_ready = 1'b0;
        step();
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("bp_wb_valid", wb_valid, 1);
            chk("bp_wb_data", wb_data, 32'h1234_5678);
            chk("bp_wb_in_ready", in_ready, 0);
            step();
        end
        wb_ready = 1'b1;
        chk("bp_wb_last", wb_data, 32'h1234_5678);
        step();
        in_valid = 1'b0;
        chk("bp_idle", in_ready, 1);
        chk("bp_no_accept", mem_req_valid, 0);

        // misaligned word load
        in_valid = 1'b1; lsu_op = 5'b01010; exu_data = 32'h8000_0001;
        step();
        in_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_no_req", mem_req_valid, 0);
        chk("mis_wb_valid", wb_valid, 1);
        chk("mis_wb_fault", wb_fault, 1);
        chk("mis_wb_data", wb_data, 32'h8000_0001);
        step();
`else
        chk("mis_req_valid", mem_req_valid, 1);
        chk("mis_req_addr", mem_req_addr, 32'h8000_0000);
        step();
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D;
        step();
        mem_resp_valid = 1'b0;
        chk("mis_wb_valid", wb_valid, 1);
        chk("mis_wb_fault", wb_fault, 0);
        chk("mis_wb_data", wb_data, 32'hCAFE_F00D);
        step();
`endif
        chk("mis_idle", in_ready, 1);

        // reset while waiting for the response
        in_valid = 1'b1; lsu_op = 5'b01000; exu_data = 32'h8000_0000;
        step();
        in_valid = 1'b0;
        step();
        chk("rw_in_wait", in_ready, 0);
        chk("rw_wait_no_req", mem_req_valid, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rw_idle", in_ready, 1);
        chk("rw_no_wb", wb_valid, 0);
        chk("rw_wb_data", wb_data, 0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hAAAA_AAAA;
        step();
        mem_resp_valid = 1'b0;
        chk("rw_resp_ignored", wb_valid, 0);
        chk("rw_still_idle", in_ready, 1);

        // unsigned half load after reset
        in_valid = 1'b1; lsu_op = 5'b01101; exu_data = 32'h8000_0002;
        step();
        in_valid = 1'b0;
        chk("lhu_req_addr", mem_req_addr, 32'h8000_0000);
        step();
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h8001_1234;
        step();
        mem_resp_valid = 1'b0;
        chk("lhu_wb_valid", wb_valid, 1);
        chk("lhu_wb_data", wb_data, 32'h0000_8001);
        step();
        chk("lhu_idle", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store stage directly downstream of EXU; consumes `EXU_data` as the effective address (or as the ALU result for non-memory ops).
- Issues at most one word-aligned request at a time on a valid/ready memory bus.
- Aligns and sign/zero-extends load data; produces one writeback beat per accepted instruction.
- Multi-cycle; backpressures EXU through `in_ready`.

Parameters:
- AW, 32, address width.
- DW, 32, data width; fixed at 32 (byte-lane logic assumes 4 lanes).

Ports:
- clk  input  1  clock
- rst  input  1  reset
- in_valid  input  1  EXU result valid
- in_ready  output  1  LSU can accept
- exu_data  input  32  EXU_data: address, or result for pass-through
- store_data  input  32  rs2 value for stores
- lsu_op  input  5  [1:0] size: 00 byte, 01 half, 10 word, 11 → treated as word; [2] unsigned load; [4:3] kind: 00 pass, 01 load, 10 store, 11 → pass
- mem_req_valid  output  1  request valid
- mem_req_ready  input  1  memory accepts
- mem_req_wen  output  1  1 = store
- mem_req_addr  output  32  word address {addr[31:2],2'b00}
- mem_req_wdata  output  32  lane-replicated store data
- mem_req_wmask  output  4  byte enables; 0 for loads
- mem_resp_valid  input  1  read data / write ack
- mem_resp_rdata  input  32  read word
- wb_valid  output  1  result valid
- wb_ready  input  1  WBU accepts
- wb_data  output  32  result
- wb_fault  output  1  misaligned access flag

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, mem_req_valid=0, wb_valid=0, wb_fault=0, wb_data=0, mem_req_* registers=0; in_ready=1 the cycle after reset.
- FSM states: IDLE, REQ, WAIT, DONE. `in_ready` = (state==IDLE).
- IDLE:
  - On in_valid, latch exu_data, store_data and lsu_op.
  - Pass-through kind → DONE with wb_data=exu_data.
  - Load/store kind → REQ.
- REQ: mem_req_valid=1; all request fields held stable until mem_req_ready. On the handshake → WAIT and drop valid.
- WAIT:
  - mem_resp_valid is sampled only in WAIT. The memory responds at least 1 cycle after the request handshake; a response in any other state is ignored.
  - On response → DONE. Load: wb_data = extended lane. Store: wb_data = 0.
- DONE: wb_valid=1; wb_data and wb_fault held stable until wb_ready, then → IDLE. Back-to-back throughput is at best one op per 2 cycles.
- Latency, no stalls: pass-through wb_valid at N+1; memory op wb_valid at N+3 with a 1-cycle response (accept N, request N+1, response N+2).
- Store mask: byte 0001<<a[1:0]; half 0011<<a[1:0]; word 1111.
- Store data: byte {4{sd[7:0]}}; half {2{sd[15:0]}}; word sd.
- Load extract: r = rdata >> (8*a[1:0]). Byte → r[7:0]; half → r[15:0]; sign-extend unless lsu_op[2]=1. Word ignores lsu_op[2].
- Misaligned: half with a[0]=1; word with a[1:0]≠0.
- rst mid-operation: forces IDLE; any outstanding response is discarded (ignored in IDLE); mem_req_valid drops the same edge.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - A misaligned load/store issues no memory request.
  - IDLE → DONE with wb_fault=1 and wb_data=exu_data (faulting address).
- Undefined:
  - wb_fault is constant 0.
  - Misaligned low bits are forced down: half uses {a[1],1'b0}, word uses 2'b00.
  - The access proceeds normally.

Decomposition:
- Package lsu_pkg:
  - lsu_op field positions;
  - size codes (SZ_B/SZ_H/SZ_W);
  - kind codes (K_PASS/K_LOAD/K_STORE);
  - state enum (S_IDLE/S_REQ/S_WAIT/S_DONE).
- Sub-module lsu_lane (combinational): mask/wdata generation, load extract/extend, misalign detect.

Test Plan:
- Pass-through op, exu_data=0x0000_1234, wb_ready=1 → wb_valid one cycle later, wb_data=0x0000_1234, no mem_req_valid.
- Signed byte load: addr 0x8000_0003, rdata 0x80FF_FF7F → mem_req_addr 0x8000_0000, wmask 0, wb_data 0xFFFF_FF80. Same with unsigned → 0x0000_0080.
- Half store: addr 0x8000_0002, store_data 0xDEAD_BEEF → wmask 1100, wdata 0xBEEF_BEEF; wb_data 0 after ack.
- Backpressure: mem_req_ready low 3 cycles, then wb_ready low 2 cycles → request fields and wb_data stable throughout; in_ready=0 until wb handshake.
- Word load at 0x8000_0001:
  - with LSU_MISALIGN_TRAP_EN → no request, wb_fault=1, wb_data 0x8000_0001;
  - without → request to 0x8000_0000, wb_fault=0.
- Assert rst while in WAIT, then pulse mem_resp_valid → state IDLE, no wb_valid, next op executes correctly.
